// File: rtl/femto_arb_pkg.sv
// Shared types for the MappedSPIRAM two-requester arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, requester IDs, operation codes.
package femto_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Requester IDs: 0 is the CPU data path, 1 is the DMA buffer mover
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Latched operation of a pending request
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // A write strobe wins when both strobes arrive together
  function automatic op_t strobe_op(input logic wr);
    return wr ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// 2-way round-robin picker: chooses which pending requester goes next.
// Latency: purely combinational, no state.
// Backpressure: none; the caller only consumes the grant when it is idle.
// Ports:
//   pend        - pending flags, bit N = requester N
//   last_grant  - ID of the most recently granted requester
//   grant_valid - at least one request is pending
//   grant_id    - requester to serve next
module arb_rr2
  import femto_arb_pkg::*;
(
  input  logic [1:0] pend,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |pend;
    grant_id    = REQ_CPU;
    if (pend == 2'b11) begin
      // contention: the requester not served last time goes first
      grant_id = ~last_grant;
    end else if (pend[REQ_DMA]) begin
      grant_id = REQ_DMA;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares the MappedSPIRAM word port between the CPU (m0) and a DMA master (m1).
// Latency: uncontended completion = downstream busy cycles + 3 after the strobe.
// Backpressure: mN_busy stays high while a request is pending; strobes seen while busy are dropped.
// Ports:
//   clk, reset           - system clock, synchronous active-high reset
//   mN_word_address/wdata/rd/wr - requester N strobe interface (FemtoRV32 style)
//   mN_busy, mN_rdata    - requester N outstanding flag and registered read data
//   ram_*                - single MappedSPIRAM word port (strobes out, busy/rdata in)
//   timeout_err          - sticky flag set when the downstream hangs past TIMEOUT cycles
module spi_ram_arbiter
  import femto_arb_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_word_address,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_rd,
  input  logic              m0_wr,
  output logic              m0_busy,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic [ADDR_W-1:0] m1_word_address,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_rd,
  input  logic              m1_wr,
  output logic              m1_busy,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_word_address,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rd,
  output logic              ram_wr,
  input  logic              ram_rbusy,
  input  logic              ram_wbusy,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              timeout_err
);

  // Wide enough to hold TIMEOUT itself; still legal when TIMEOUT is 0
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        pend;
  logic [ADDR_W-1:0] addr_q  [2];
  logic [DATA_W-1:0] wdata_q [2];
  op_t               op_q    [2];
  logic              last_grant;
  logic              cur;
  logic [CNT_W-1:0]  wd_cnt;

  logic [1:0]        rd_in;
  logic [1:0]        wr_in;
  logic [ADDR_W-1:0] addr_in  [2];
  logic [DATA_W-1:0] wdata_in [2];

  logic              grant_valid;
  logic              grant_id;
  logic              grant;
  logic              done;
  logic              forced;
  logic              wd_expired;
  logic [DATA_W-1:0] rsp;

  assign rd_in       = {m1_rd, m0_rd};
  assign wr_in       = {m1_wr, m0_wr};
  assign addr_in[0]  = m0_word_address;
  assign addr_in[1]  = m1_word_address;
  assign wdata_in[0] = m0_wdata;
  assign wdata_in[1] = m1_wdata;

  // busy is exactly the registered pending flag
  assign m0_busy = pend[REQ_CPU];
  assign m1_busy = pend[REQ_DMA];

  arb_rr2 u_rr (
    .pend        (pend),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign grant      = (state == ST_IDLE) && grant_valid;
  assign wd_expired = (TIMEOUT != 0) && (wd_cnt == CNT_W'(TIMEOUT));
  // a watchdog-forced read returns zero rather than whatever the bus holds
  assign rsp        = forced ? '0 : ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    done      = 1'b0;
    forced    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ram_rd    = (op_q[cur] == OP_RD);
        ram_wr    = (op_q[cur] == OP_WR);
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!(ram_rbusy || ram_wbusy)) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wd_expired) begin
          done      = 1'b1;
          forced    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend             <= '0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        op_q[i]    <= OP_RD;
      end
      last_grant       <= REQ_DMA;
      cur              <= REQ_CPU;
      wd_cnt           <= '0;
      ram_word_address <= '0;
      ram_wdata        <= '0;
      m0_rdata         <= '0;
      m1_rdata         <= '0;
      timeout_err      <= 1'b0;
    end else begin
      // capture only when idle; a strobe while busy is dropped
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && (rd_in[i] || wr_in[i])) begin
          pend[i]    <= 1'b1;
          addr_q[i]  <= addr_in[i];
          wdata_q[i] <= wdata_in[i];
          op_q[i]    <= strobe_op(wr_in[i]);
        end
      end

      if (grant) begin
        cur              <= grant_id;
        last_grant       <= grant_id;
        ram_word_address <= addr_q[grant_id];
        ram_wdata        <= wdata_q[grant_id];
      end

      if (state == ST_ISSUE) begin
        wd_cnt <= '0;
      end else if ((state == ST_WAIT) && !done) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (done) begin
        pend[cur] <= 1'b0;
        if (op_q[cur] == OP_RD) begin
          if (cur == REQ_CPU) begin
            m0_rdata <= rsp;
          end else begin
            m1_rdata <= rsp;
          end
        end
      end

      if (forced) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Shares the single MappedSPIRAM word port (dpRAM window, 0x0001_xxxx) between two requesters.
- Requester 0 is the FemtoRV32 CPU data path; requester 1 is a DMA-style master (UART buffer mover).
- Latches each requester's rd/wr strobe, grants round-robin, sequences one downstream transaction at a time, and returns per-requester busy and read data with FemtoRV32 strobe/busy semantics.
- Includes a downstream-hang watchdog.

Parameters:
ADDR_W, 20, word address width (byte address bits [21:2])
DATA_W, 32, data word width
TIMEOUT, 1024, max cycles the downstream may hold busy; 0 disables the watchdog

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_word_address  in  ADDR_W  requester 0 word address
m0_wdata  in  DATA_W  requester 0 write data
m0_rd  in  1  requester 0 read strobe (one-cycle pulse)
m0_wr  in  1  requester 0 write strobe (one-cycle pulse)
m0_busy  out  1  requester 0 transaction outstanding
m0_rdata  out  DATA_W  requester 0 read data, registered
m1_word_address  in  ADDR_W  requester 1 word address
m1_wdata  in  DATA_W  requester 1 write data
m1_rd  in  1  requester 1 read strobe
m1_wr  in  1  requester 1 write strobe
m1_busy  out  1  requester 1 transaction outstanding
m1_rdata  out  DATA_W  requester 1 read data, registered
ram_word_address  out  ADDR_W  to MappedSPIRAM
ram_wdata  out  DATA_W  to MappedSPIRAM
ram_rd  out  1  one-cycle read strobe to MappedSPIRAM
ram_wr  out  1  one-cycle write strobe to MappedSPIRAM
ram_rbusy  in  1  MappedSPIRAM read busy
ram_wbusy  in  1  MappedSPIRAM write busy
ram_rdata  in  DATA_W  MappedSPIRAM read data, valid when rbusy falls
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values:
  - Outputs: all busy=0, m0_rdata=m1_rdata=0, ram_rd=ram_wr=0, ram_word_address=ram_wdata=0, timeout_err=0.
  - Internal: state=IDLE, pending flags cleared, last_grant=1 (requester 0 wins first tie).
- Capture:
  - A strobe on mN_rd or mN_wr while mN_busy=0 sets pend_N. It also latches addr, wdata and op (wr if mN_wr, else rd; wr wins if both asserted).
  - A strobe while mN_busy=1 is ignored.
- Busy:
  - mN_busy = pend_N, a registered signal, so it is high from the cycle after the strobe through the completion cycle.
  - mN_busy falls the cycle after completion.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If no pending requests, stay in IDLE.
  - If exactly one is pending, grant it.
  - If both are pending, grant the one that is not last_grant.
  - On grant: load ram_word_address/ram_wdata from the granted latch, set last_grant, go to ISSUE.
- ISSUE:
  - ram_rd or ram_wr is high for exactly one cycle according to the latched op.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - Address and wdata are held stable.
  - If ram_rbusy|ram_wbusy = 0, the transaction completes:
    - For a read, capture ram_rdata into mN_rdata.
    - Clear pend_N and go to IDLE.
  - Otherwise increment the watchdog counter.
- Watchdog: if TIMEOUT≠0 and the counter reaches TIMEOUT, force completion. mN_rdata is set to 0 for a read, timeout_err is set (sticky until reset), then go to IDLE.
- Latency: an uncontended transaction completes downstream latency + 3 cycles after the strobe (capture, IDLE, ISSUE).
- Contention: a waiting requester is served immediately after the current transaction, so it waits at most one full transaction. Strict alternation holds under continuous load from both requesters.
- mN_rdata changes only on completion of that requester's read; writes and the other requester's traffic leave it unchanged.
- ram_rd/ram_wr are never asserted outside ISSUE; at most one of them is high in any cycle.
- A new strobe from the non-granted requester during WAIT is captured normally.
- Reset mid-transaction: synchronous return to IDLE with every reset value above; the latched op is dropped. The shared reset also resets MappedSPIRAM.

Decomposition:
- Shared package femto_arb_pkg:
  - State encoding constants ST_IDLE/ST_ISSUE/ST_WAIT.
  - Requester IDs REQ_CPU=0, REQ_DMA=1.
  - OP_RD/OP_WR.
- One natural sub-module, arb_rr2: 2-way round-robin picker.
  - Inputs: pend[1:0], last_grant. Outputs: grant_valid, grant_id.
  - Purely combinational; the arbiter top holds all state.

Test Plan:
1. Single read: m0_rd at addr 0x00010 with a downstream model of busy 8 cycles returning 0xCAFEBABE -> ram_rd one cycle, m0_busy high from T+1, m0_rdata=0xCAFEBABE, m0_busy low at T+12.
2. Simultaneous strobes after reset: m0_wr 0x00005/0x11111111 and m1_rd 0x00006 in the same cycle -> requester 0 is issued first, then requester 1; m1_busy is held throughout; m1_rdata is updated, m0_rdata stays 0.
3. Continuous load: both requesters re-strobe the cycle after their busy falls for 10 transactions each -> grants strictly alternate, 20 downstream strobes total, never two ram strobes in one cycle.
4. Ignored strobe: m1_rd pulsed while m1_busy=1 -> no extra downstream transaction; the latched address is unchanged.
5. Watchdog: TIMEOUT=16 with ram_rbusy stuck high -> completion forced 16 cycles into WAIT, m0_rdata=0, timeout_err=1 and held; the next request from requester 1 proceeds normally.
6. Reset during WAIT -> next cycle: state IDLE, busy outputs 0, rdata 0, timeout_err 0, no pending requests.
